// File: rtl/m_dynamic_display_pkg.sv
// Shared constants for the multiplexed 7-segment driver: digit width, blank pattern,
// the hex-to-segment table and the scan state encoding exposed for debug.
package m_dynamic_display_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low patterns {dp,g..a}; entry 0 sits in the low byte.
  localparam logic [16*8-1:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hA7, 8'h83, 8'h88, 8'h98, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    SCAN_DARK  = 2'd0,
    SCAN_BLANK = 2'd1,
    SCAN_LIT   = 2'd2
  } scan_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = SEG_LUT[{digit, 3'b000} +: 7];
    return pattern;
  endfunction

endpackage

// File: rtl/m_dynamic_display_if.sv
// Display bundle between the counter chain (master) and the scan driver (slave).
interface m_dynamic_display_if
  import m_dynamic_display_pkg::*;
#(
  parameter int DIGITS = 4
);
  // No handshake: idat/dot_en/hold are levels sampled by the driver at its own
  // scan instants (snapshot at frame start, dp when a digit lights); seg/com are
  // registered levels valid every cycle.
  logic [DIGIT_W*DIGITS-1:0] idat;
  logic [DIGITS-1:0]         dot_en;
  logic                      hold;
  logic [7:0]                seg;
  logic [DIGITS-1:0]         com;
  scan_state_e               dbg_state;

  modport master (
    output idat, dot_en, hold,
    input  seg, com, dbg_state
  );

  modport slave (
    input  idat, dot_en, hold,
    output seg, com, dbg_state
  );
endinterface

// File: rtl/m_dynamic_display_prescaler.sv
// Free-running slot prescaler: counts 0..SCAN_DIV-1 and flags the last count as tick.
module m_scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic n_reset,
  output logic tick_o
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick_o = (cnt_q == LAST);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/m_dynamic_display.sv
// Common-anode multi-digit scan driver with frame snapshot, lap hold and a blank
// cycle between digits. Optional macro: LEADING_ZERO_BLANK_EN.
module m_dynamic_display
  import m_dynamic_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  n_reset,
  m_dynamic_display_if.slave    disp
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  logic tick;

  m_scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk     (clk),
    .n_reset (n_reset),
    .tick_o  (tick)
  );

  scan_state_e               state_q;
  logic [IW-1:0]             idx_q;
  logic [DIGIT_W*DIGITS-1:0] snap_q;
  logic [7:0]                seg_q;
  logic [DIGITS-1:0]         com_q;

  logic [DIGIT_W-1:0] cur_digit;
  logic               cur_blank;
  logic [7:0]         lit_seg;
  logic [DIGITS-1:0]  lit_com;

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[i] is set when digits i..DIGITS-1 of the snapshot are all zero.
  logic [DIGITS-1:0] zero_from;

  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (snap_q[DIGIT_W*(DIGITS-1) +: DIGIT_W] == '0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (snap_q[DIGIT_W*i +: DIGIT_W] == '0);
    end
  end

  assign cur_blank = (idx_q != '0) && zero_from[idx_q];
`else
  assign cur_blank = 1'b0;
`endif

  always_comb begin
    cur_digit = snap_q[DIGIT_W*idx_q +: DIGIT_W];
    lit_com   = ~(DIGITS'(1) << idx_q);
    lit_seg   = cur_blank ? SEG_BLANK : {~disp.dot_en[idx_q], seg_decode(cur_digit)};
  end

  // A tick always opens a blank cycle; the following clock lights the new digit,
  // which then holds until the next tick.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= SCAN_DARK;
      idx_q   <= LAST_IDX;
      snap_q  <= '0;
      seg_q   <= SEG_BLANK;
      com_q   <= '1;
    end else if (tick) begin
      state_q <= SCAN_BLANK;
      seg_q   <= SEG_BLANK;
      com_q   <= '1;
      idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      if ((idx_q == LAST_IDX) && !disp.hold) begin
        snap_q <= disp.idat;
      end
    end else if (state_q == SCAN_BLANK) begin
      state_q <= SCAN_LIT;
      seg_q   <= lit_seg;
      com_q   <= lit_com;
    end
  end

  assign disp.seg       = seg_q;
  assign disp.com       = com_q;
  assign disp.dbg_state = state_q;

endmodule
